riscv_dmem_slave: RTL and testbench

Data-memory responder on the slave side of `dualport_bus`, serving the load/store unit that issues word-aligned, byte-enabled read and write requests. It holds a synchronous word-organised RAM, grants each channel independently after a configurable number of wait cycles, and applies writes per byte lane. Read data returns one cycle after the grant. It sits between the pipeline's memory-stage master and the on-chip data RAM.

---
 rtl/riscv_dmem_slave_if.sv | 30 +++
 rtl/riscv_dmem_slave.sv | 170 +++++++++++++++++
 tb/tb_riscv_dmem_slave.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : dualport_bus
// Purpose  : Independent read and write request/grant channels between the
//            memory-stage master and a data-memory slave.
// Revision : 1.0
// ============================================================================
interface dualport_bus;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [3:0]  rd_be;
    logic        rd_gnt;
    logic [31:0] rd_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_gnt;

    modport master (
        output rd_req, rd_addr, rd_be, wr_req, wr_addr, wr_be, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, rd_be, wr_req, wr_addr, wr_be, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface
`default_nettype wire

// File: rtl/riscv_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dmem_slave
// Purpose  : Byte-enabled data RAM responder with per-channel wait-state grants.
// Revision : 1.0
// ============================================================================

// Grant generator for one channel; WAIT_CYCLES of stall before the grant.
module riscv_dmem_slave_chan #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    output logic gnt_o
);
    generate
        if (WAIT_CYCLES == 0) begin : g_comb
            logic unused_clk;
            assign unused_clk = clk;
            assign gnt_o      = req_i & rst_n;
        end else begin : g_fsm
            localparam logic [1:0] c_IDLE  = 2'd0;
            localparam logic [1:0] c_WAIT  = 2'd1;
            localparam logic [1:0] c_GRANT = 2'd2;
            localparam logic [2:0] c_LAST  = 3'(WAIT_CYCLES - 1);

            logic [1:0] state_q, state_d;
            logic [2:0] cnt_q, cnt_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= c_IDLE;
                    cnt_q   <= 3'd0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // The request cycle itself counts as the first wait cycle.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    c_IDLE: begin
                        cnt_d = 3'd0;
                        if (req_i) begin
                            if (WAIT_CYCLES == 1) begin
                                state_d = c_GRANT;
                            end else begin
                                state_d = c_WAIT;
                                cnt_d   = 3'd1;
                            end
                        end
                    end
                    c_WAIT: begin
                        if (!req_i) begin
                            state_d = c_IDLE;
                            cnt_d   = 3'd0;
                        end else if (cnt_q == c_LAST) begin
                            state_d = c_GRANT;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                    c_GRANT: begin
                        state_d = c_IDLE;
                        cnt_d   = 3'd0;
                    end
                    default: begin
                        state_d = c_IDLE;
                        cnt_d   = 3'd0;
                    end
                endcase
            end

            always_comb begin
                gnt_o = req_i & (state_q == c_GRANT);
            end
        end
    endgenerate
endmodule

module riscv_dmem_slave #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned RD_WAIT     = 0,
    parameter int unsigned WR_WAIT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    dualport_bus.slave       mem_slave,
    output logic             o_addr_err
);
    localparam int unsigned c_AW = $clog2(DEPTH_WORDS);

    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     rd_data_q;
    logic            addr_err_q;
    logic            rd_gnt, wr_gnt;
    logic [31:0]     rd_off, wr_off;
    logic            rd_ok, wr_ok, wr_fire;
    logic [c_AW-1:0] rd_idx, wr_idx;
    logic [31:0]     rd_word;

    riscv_dmem_slave_chan #(.WAIT_CYCLES(RD_WAIT)) u_rd_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (mem_slave.rd_req),
        .gnt_o (rd_gnt)
    );

    riscv_dmem_slave_chan #(.WAIT_CYCLES(WR_WAIT)) u_wr_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (mem_slave.wr_req),
        .gnt_o (wr_gnt)
    );

    assign rd_off  = mem_slave.rd_addr - BASE_ADDR;
    assign wr_off  = mem_slave.wr_addr - BASE_ADDR;
    assign rd_ok   = (mem_slave.rd_addr >= BASE_ADDR) && (rd_off[31:2] < 30'(DEPTH_WORDS));
    assign wr_ok   = (mem_slave.wr_addr >= BASE_ADDR) && (wr_off[31:2] < 30'(DEPTH_WORDS));
    assign rd_idx  = rd_off[c_AW+1:2];
    assign wr_idx  = wr_off[c_AW+1:2];
    assign wr_fire = wr_gnt & wr_ok;

    // Same-cycle write to the read word is forwarded so the write lands first.
    always_comb begin
        rd_word = mem_q[rd_idx];
        for (int k = 0; k < 4; k++) begin
            if (wr_fire && (wr_idx == rd_idx) && mem_slave.wr_be[k]) begin
                rd_word[8*k +: 8] = mem_slave.wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_slave.wr_be[k]) begin
                    mem_q[wr_idx][8*k +: 8] <= mem_slave.wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            if (rd_gnt) begin
                rd_data_q <= rd_ok ? rd_word : 32'h0;
            end
            addr_err_q <= (rd_gnt & ~rd_ok) | (wr_gnt & ~wr_ok);
        end
    end

    assign mem_slave.rd_gnt  = rd_gnt;
    assign mem_slave.wr_gnt  = wr_gnt;
    assign mem_slave.rd_data = rd_data_q;
    assign o_addr_err        = addr_err_q;

    logic unused_bits;
    assign unused_bits = ^{mem_slave.rd_be, rd_off[1:0], wr_off[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_dmem_slave
// Purpose  : Directed self-checking bench; zero-wait and wait-state instances.
// Revision : 1.0
// ============================================================================
module tb_riscv_dmem_slave;
    logic clk = 1'b0;
    logic rst0_n, rst1_n;
    logic err0, err1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dualport_bus b0 ();
    dualport_bus b1 ();

    riscv_dmem_slave #(
        .DEPTH_WORDS(4096), .BASE_ADDR(32'h0001_0000), .RD_WAIT(0), .WR_WAIT(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .mem_slave(b0), .o_addr_err(err0)
    );

    riscv_dmem_slave #(
        .DEPTH_WORDS(4096), .BASE_ADDR(32'h0001_0000), .RD_WAIT(3), .WR_WAIT(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .mem_slave(b1), .o_addr_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b0.rd_req = 0; b0.rd_addr = 0; b0.rd_be = 0;
        b0.wr_req = 0; b0.wr_addr = 0; b0.wr_be = 0; b0.wr_data = 0;
        b1.rd_req = 0; b1.rd_addr = 0; b1.rd_be = 0;
        b1.wr_req = 0; b1.wr_addr = 0; b1.wr_be = 0; b1.wr_data = 0;
        rst0_n = 0; rst1_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_gnt",  32'(b0.rd_gnt), 32'h0);
        check("rst_wr_gnt",  32'(b0.wr_gnt), 32'h0);
        check("rst_rd_data", b0.rd_data, 32'h0);
        check("rst_err",     32'(err0), 32'h0);
        check("rst1_rd_data", b1.rd_data, 32'h0);
        @(negedge clk); rst0_n = 1; rst1_n = 1;

        // ---------------- zero-wait instance ----------------
        @(negedge clk); b0.rd_req = 1; b0.rd_addr = 32'h0001_0000; b0.rd_be = 4'hF;
        #1 check("rd0_gnt_same_cycle", 32'(b0.rd_gnt), 32'h1);
        @(posedge clk); #1 check("rd0_err", 32'(err0), 32'h0);

        @(negedge clk); b0.rd_req = 0;
        b0.wr_req = 1; b0.wr_addr = 32'h0001_0004; b0.wr_data = 32'hDEADBEEF; b0.wr_be = 4'hF;
        #1 check("wr0_gnt_a", 32'(b0.wr_gnt), 32'h1);
        @(negedge clk); b0.wr_data = 32'h0000AA00; b0.wr_be = 4'b0010;
        #1 check("wr0_gnt_b", 32'(b0.wr_gnt), 32'h1);
        @(negedge clk); b0.wr_req = 0; b0.rd_req = 1; b0.rd_addr = 32'h0001_0004;
        #1 check("rd0_gnt_lane", 32'(b0.rd_gnt), 32'h1);
        @(posedge clk); #1 check("rd0_lane_data", b0.rd_data, 32'hDEADAAEF);

        // Collision: read and write the same word in one cycle
        @(negedge clk); b0.rd_req = 0;
        b0.wr_req = 1; b0.wr_addr = 32'h0001_0008; b0.wr_data = 32'h11223344; b0.wr_be = 4'hF;
        @(negedge clk); b0.rd_req = 1; b0.rd_addr = 32'h0001_0008;
        b0.wr_data = 32'h000000FF; b0.wr_be = 4'b0001;
        #1 check("coll_both_gnt", {30'h0, b0.rd_gnt, b0.wr_gnt}, 32'h3);
        @(posedge clk); #1 check("coll_rd_data", b0.rd_data, 32'h112233FF);
        @(negedge clk); b0.wr_data = 32'hFFFFFFFF; b0.wr_be = 4'b0000;
        @(posedge clk); #1 check("be0_noop_rd", b0.rd_data, 32'h112233FF);
        @(negedge clk); b0.wr_req = 0;
        @(posedge clk); #1 check("coll_ram_held", b0.rd_data, 32'h112233FF);

        // Out-of-range: 0xFFFC would alias the last word if not dropped
        @(negedge clk); b0.rd_req = 0;
        b0.wr_req = 1; b0.wr_addr = 32'h0001_3FFC; b0.wr_data = 32'h5A5A5A5A; b0.wr_be = 4'hF;
        @(negedge clk); b0.rd_req = 1; b0.rd_addr = 32'h0001_4000;
        b0.wr_addr = 32'h0000_FFFC; b0.wr_data = 32'hFFFFFFFF;
        #1 check("oor_both_gnt", {30'h0, b0.rd_gnt, b0.wr_gnt}, 32'h3);
        check("oor_err_before", 32'(err0), 32'h0);
        @(posedge clk); #1;
        check("oor_rd_zero", b0.rd_data, 32'h0);
        check("oor_err_pulse", 32'(err0), 32'h1);
        @(negedge clk); b0.wr_req = 0; b0.rd_addr = 32'h0001_3FFC;
        @(posedge clk); #1;
        check("oor_err_once", 32'(err0), 32'h0);
        check("oor_ram_kept", b0.rd_data, 32'h5A5A5A5A);
        @(negedge clk); b0.rd_req = 0;

        // ---------------- wait-state instance ----------------
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b1.wr_req = 1; b1.wr_addr = 32'h0001_0010;
                b1.wr_data = 32'hCAFEF00D; b1.wr_be = 4'hF;
            end
            #1 check($sformatf("wr1_gnt_c%0d", k), 32'(b1.wr_gnt), 32'(k == 2));
        end
        @(negedge clk); b1.wr_req = 0;

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b1.rd_req = 1; b1.rd_addr = 32'h0001_0010; b1.rd_be = 4'hF;
            end
            #1 check($sformatf("rd1_gnt_c%0d", k), 32'(b1.rd_gnt), 32'(k == 3));
            if (k == 2) check("rd1_data_early", b1.rd_data, 32'h0);
        end
        @(posedge clk); #1 check("rd1_data_c4", b1.rd_data, 32'hCAFEF00D);
        @(negedge clk); b1.rd_req = 0;

        // Drop request mid-wait, then a held request granting twice
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b1.rd_req = (k == 0);
            #1 check($sformatf("drop_gnt_c%0d", k), 32'(b1.rd_gnt), 32'h0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            b1.rd_req = 1;
            #1 check($sformatf("held_gnt_c%0d", k), 32'(b1.rd_gnt), 32'((k == 3) || (k == 7)));
        end
        @(negedge clk); b1.rd_req = 0;

        // Asynchronous reset during the write wait
        @(negedge clk); b1.wr_req = 1; b1.wr_addr = 32'h0001_0010;
        b1.wr_data = 32'h12345678; b1.wr_be = 4'hF;
        #1 check("rstw_gnt_c0", 32'(b1.wr_gnt), 32'h0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); rst1_n = 0;
            #1 check($sformatf("rstw_gnt_c%0d", k), 32'(b1.wr_gnt), 32'h0);
        end
        check("rstw_rd_data", b1.rd_data, 32'h0);
        @(negedge clk); b1.wr_req = 0; rst1_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b1.rd_req = 1; b1.rd_addr = 32'h0001_0010;
            #1 check($sformatf("rstw_rd_gnt_c%0d", k), 32'(b1.rd_gnt), 32'(k == 3));
        end
        @(posedge clk); #1 check("rstw_word_kept", b1.rd_data, 32'hCAFEF00D);
        @(negedge clk); b1.rd_req = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
